// File: rtl/fpm_issue_arbiter_if.sv
// Requester-side bundle for fpm_issue_arbiter: operand requests in, products out.
// master = requester cluster, slave = arbiter.
interface fpm_issue_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_data;

  modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fpm_issue_arbiter.sv
// Shares one free-running pipelined FP multiplier among NREQ requesters and routes products back.
// FPM_ARB_RR_EN: round-robin priority when defined, fixed lowest-index priority otherwise.
module fpm_issue_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  fpm_issue_arbiter_if.slave  s_if,
  output logic [31:0]         o_mul_a,
  output logic [31:0]         o_mul_b,
  input  logic [31:0]         i_mul_p,
  output logic [3:0]          o_inflight,
  output logic                o_idle
);

  logic [NREQ-1:0]       w_gnt;
  logic                  w_gnt_vld;
  logic [2:0]            w_gnt_id;
  logic [31:0]           w_a, w_b;
  logic [2:0]            w_base;
  logic [NREQ-1:0]       w_rsp_oh;

  logic [31:0]           r_mul_a, r_mul_b, r_rsp_data;
  logic [NREQ-1:0]       r_rsp_valid;
  logic [3:0]            r_inflight;
  logic [LAT:0]          r_vld_pipe;
  logic [LAT:0][2:0]     r_id_pipe;

`ifdef FPM_ARB_RR_EN
  logic [2:0] r_ptr;
  assign w_base = r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ptr <= '0;
    else if (w_gnt_vld) r_ptr <= (w_gnt_id == 3'(NREQ-1)) ? 3'd0 : w_gnt_id + 3'd1;
  end
`else
  assign w_base = 3'd0;
`endif

  // Rotating search: indices >= base first, then the wrapped indices below base.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_a       = '0;
    w_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i_en && !w_gnt_vld && s_if.req_valid[i] && (3'(i) >= w_base)) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 3'(i);
        w_a       = s_if.req_a[i];
        w_b       = s_if.req_b[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (i_en && !w_gnt_vld && s_if.req_valid[i] && (3'(i) < w_base)) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 3'(i);
        w_a       = s_if.req_a[i];
        w_b       = s_if.req_b[i];
      end
    end
    w_gnt = '0;
    for (int i = 0; i < NREQ; i++) w_gnt[i] = w_gnt_vld && (w_gnt_id == 3'(i));
  end

  always_comb begin
    w_rsp_oh = '0;
    for (int i = 0; i < NREQ; i++) w_rsp_oh[i] = r_vld_pipe[LAT] && (r_id_pipe[LAT] == 3'(i));
  end

  // Tag pipe mirrors the multiplier depth plus the operand register; it never stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LAT-1:0], w_gnt_vld};
      r_id_pipe  <= {r_id_pipe[LAT-1:0], w_gnt_id};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
      r_inflight  <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_mul_a <= w_a;
        r_mul_b <= w_b;
      end
      if (r_vld_pipe[LAT]) r_rsp_data <= i_mul_p;
      r_rsp_valid <= w_rsp_oh;
      case ({w_gnt_vld, r_vld_pipe[LAT]})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign s_if.req_ready = w_gnt;
  assign s_if.rsp_valid = r_rsp_valid;
  assign s_if.rsp_data  = r_rsp_data;
  assign o_mul_a        = r_mul_a;
  assign o_mul_b        = r_mul_b;
  assign o_inflight     = r_inflight;
  assign o_idle         = (r_inflight == 4'd0);

endmodule

// File: tb/tb_fpm_issue_arbiter.sv
// Randomized bench for fpm_issue_arbiter: behavioural multiplier, op scoreboard keyed by issue cycle.
module tb_fpm_issue_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic        clk, rst_n, i_en;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [3:0]  inflight;
  logic        idle;

  fpm_issue_arbiter_if #(.NREQ(NREQ)) bus();

  fpm_issue_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .s_if(bus),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_p(mul_p),
    .o_inflight(inflight), .o_idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IEEE single multiply for normal operands (zero exponent treated as signed zero), RNE.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s; int e; logic [47:0] p; logic [23:0] m; logic r, st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[47:24]; r = p[23]; st = |p[22:0]; e++; end
    else       begin m = p[46:23]; r = p[22]; st = |p[21:0]; end
    if (r && (st || m[0])) begin
      m = m + 24'd1;
      if (m == 24'd0) begin m = 24'h800000; e++; end
    end
    return {s, e[7:0], m[22:0]};
  endfunction

  // Multiplier stand-in: product of the registered operands appears LAT cycles later.
  logic [31:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_p = mp[LAT-1];

  typedef struct { int id; logic [31:0] d; int t; } op_t;
  op_t q[$];
  int cyc, n_chk, n_err, m_ptr;
  logic [31:0] m_a, m_b, m_rsp;
  logic [NREQ-1:0][31:0] drv_a, drv_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin drv_a[i] = rand_fp(); drv_b[i] = rand_fp(); end
  endtask

  // Registered outputs in cycle cyc: an op granted in cycle t is in flight for t+1..t+LAT+1
  // and is returned (strobe + data) in cycle t+LAT+2.
  task automatic check_regs();
    logic [NREQ-1:0] ev;
    int inf;
    ev = '0; inf = 0;
    foreach (q[j]) begin
      if (q[j].t + LAT + 2 == cyc) begin
        for (int i = 0; i < NREQ; i++) if (i == q[j].id) ev[i] = 1'b1;
        m_rsp = q[j].d;
      end else if (q[j].t + 1 <= cyc && cyc <= q[j].t + LAT + 1) inf++;
    end
    while (q.size() > 0 && q[0].t + LAT + 2 <= cyc) void'(q.pop_front());
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    chk("rsp_data",  bus.rsp_data, m_rsp);
    chk("inflight",  32'(inflight), 32'(inf));
    chk("idle",      32'(idle), 32'(inf == 0));
    chk("mul_a",     mul_a, m_a);
    chk("mul_b",     mul_b, m_b);
  endtask

  task automatic cycle(input logic en, input logic [NREQ-1:0] v);
    int g, idx;
    logic [NREQ-1:0] er;
    check_regs();
    i_en = en; bus.req_valid = v; bus.req_a = drv_a; bus.req_b = drv_b;
    #1;
    g = -1;
    if (en) for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    er = '0;
    for (int i = 0; i < NREQ; i++) if (i == g) er[i] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (g >= 0) begin
      q.push_back('{g, fmul(drv_a[g], drv_b[g]), cyc});
      m_a = drv_a[g]; m_b = drv_b[g];
`ifdef FPM_ARB_RR_EN
      m_ptr = (g + 1) % NREQ;
`endif
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.req_valid = '0; i_en = 1'b0;
    #1;
    q.delete(); m_ptr = 0; m_a = '0; m_b = '0; m_rsp = '0;
    check_regs();
    @(posedge clk); cyc++; @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; i_en = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    rand_ops();
    @(negedge clk);
    do_reset();

    // Single request from requester 1: 2.0 * 3.0
    for (int n = 0; n < 3; n++) begin rand_ops(); cycle(1'b1, '0); end
    drv_a[1] = 32'h40000000; drv_b[1] = 32'h40400000;
    cycle(1'b1, 4'b0010);
    for (int n = 0; n < 5; n++) cycle(1'b1, '0);
    chk("t1_data", bus.rsp_data, 32'h40C00000);
    chk("t1_vld",  32'(bus.rsp_valid), 32'h2);
    chk("t1_idle", 32'(idle), 32'h1);

    // All requesters saturated
    for (int n = 0; n < 8; n++) begin rand_ops(); cycle(1'b1, 4'hF); end
    for (int n = 0; n < 8; n++) cycle(1'b1, '0);

    // Back-to-back mixed values: 1.5*1.5 then 0*2
    drv_a[3] = 32'h3FC00000; drv_b[3] = 32'h3FC00000;
    cycle(1'b1, 4'b1000);
    drv_a[0] = 32'h00000000; drv_b[0] = 32'h40000000;
    cycle(1'b1, 4'b0001);
    for (int n = 0; n < 4; n++) cycle(1'b1, '0);
    chk("mix_d3", bus.rsp_data, 32'h40100000);
    chk("mix_v3", 32'(bus.rsp_valid), 32'h8);
    cycle(1'b1, '0);
    chk("mix_d0", bus.rsp_data, 32'h00000000);
    chk("mix_v0", 32'(bus.rsp_valid), 32'h1);

    // Enable drain with requester 2 still asserting valid
    for (int n = 0; n < 3; n++) begin rand_ops(); cycle(1'b1, 4'b0100); end
    for (int n = 0; n < 9; n++) begin rand_ops(); cycle(1'b0, 4'b0100); end

    // Reset with ops in flight, then a fresh op
    for (int n = 0; n < 3; n++) begin rand_ops(); cycle(1'b1, 4'($urandom_range(1, 15))); end
    do_reset();
    rand_ops();
    cycle(1'b1, 4'b0010);
    for (int n = 0; n < 8; n++) cycle(1'b1, '0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      cycle($urandom_range(0, 7) != 0, 4'($urandom));
    end
    for (int n = 0; n < 8; n++) cycle(1'b1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
